// File: rtl/wash_pkg.sv
// Shared types and defaults for the wash sequencer: state encoding, phase
// durations, programme group bit positions and a saturation helper.
package wash_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FILL_W  = 4'd1,
    WASH    = 4'd2,
    DRAIN_R = 4'd3,
    SPIN_R  = 4'd4,
    FILL_R  = 4'd5,
    RINSE   = 4'd6,
    DRAIN_D = 4'd7,
    SPIN_D  = 4'd8,
    DONE    = 4'd9,
    PAUSE   = 4'd10
  } washState_t;

  localparam int DEF_FILL_T  = 2;
  localparam int DEF_WASH_T  = 6;
  localparam int DEF_RINSE_T = 4;
  localparam int DEF_DRAIN_T = 2;
  localparam int DEF_SPIN_T  = 3;

  // mode bit positions: {dry, rinse, wash}
  localparam int GRP_WASH  = 0;
  localparam int GRP_RINSE = 1;
  localparam int GRP_DRY   = 2;

  function automatic logic [7:0] sat8(input int v);
    logic [7:0] r;
    if (v > 32'sd255) begin
      r = 8'd255;
    end else if (v < 32'sd0) begin
      r = 8'd0;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/wash_sequencer_if.sv
// Operator inputs and actuator/status outputs of the wash sequencer.
interface wash_sequencer_if;
  logic       runBtn;
  logic       openBtn;
  logic       tick_1s;
  logic [2:0] mode;
  logic [2:0] water_lvl;
  logic       inWater;
  logic       washing;
  logic       outWater;
  logic       spinning;
  logic       rinsing;
  logic       busy;
  logic       paused;
  logic       done;
  logic [3:0] phase;
  logic [7:0] remaining;
  logic       beep;

  modport master (
    output runBtn, openBtn, tick_1s, mode, water_lvl,
    input  inWater, washing, outWater, spinning, rinsing,
    input  busy, paused, done, phase, remaining, beep
  );

  modport slave (
    input  runBtn, openBtn, tick_1s, mode, water_lvl,
    output inWater, washing, outWater, spinning, rinsing,
    output busy, paused, done, phase, remaining, beep
  );
endinterface

// File: rtl/wash_sequencer_phase_timer.sv
// Per-phase countdown: load has priority, decrements on unheld ticks,
// floors at zero and flags zero.
module phase_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] loadVal,
  input  logic       tick,
  input  logic       hold,
  output logic       zero
);

  logic [7:0] value_r;

  // countdown register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_r <= 8'd0;
    end else if (load) begin
      value_r <= loadVal;
    end else if (tick && !hold && (value_r != 8'd0)) begin
      value_r <= value_r - 8'd1;
    end else begin
      value_r <= value_r;
    end
  end

  assign zero = (value_r == 8'd0);

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine programme sequencer. Define WASH_SEQ_BEEP_EN to get a
// three-second end-of-cycle beep; otherwise beep is tied low.
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int FILL_T  = DEF_FILL_T,
  parameter int WASH_T  = DEF_WASH_T,
  parameter int RINSE_T = DEF_RINSE_T,
  parameter int DRAIN_T = DEF_DRAIN_T,
  parameter int SPIN_T  = DEF_SPIN_T
) (
  input logic              clk,
  input logic              resetBtn,
  wash_sequencer_if.slave  bus
);

  washState_t state_r, nextState_s, stored_r, nextPhase_s, startState_s;
  logic [2:0] mode_r, lvl_r, lvlIn_s;
  logic [7:0] remaining_r, tmrVal_s;
  logic       openPrev_r, tmrLoad_s, tmrZero_s, start_s;
  logic       running_s, userEvt_s, countTick_s;
  logic       inWater_r, washing_r, outWater_r, spinning_r, rinsing_r;
  logic       busy_r, paused_r, done_r;

  function automatic logic isRunning(input washState_t s);
    logic r;
    case (s)
      FILL_W, WASH, DRAIN_R, SPIN_R, FILL_R, RINSE, DRAIN_D, SPIN_D: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Successor of a phase; disabled groups are skipped.
  function automatic washState_t followOn(input washState_t s, input logic [2:0] m);
    washState_t n;
    case (s)
      IDLE:    n = m[GRP_WASH] ? FILL_W : (m[GRP_RINSE] ? DRAIN_R : (m[GRP_DRY] ? DRAIN_D : DONE));
      FILL_W:  n = WASH;
      WASH:    n = m[GRP_RINSE] ? DRAIN_R : (m[GRP_DRY] ? DRAIN_D : DONE);
      DRAIN_R: n = SPIN_R;
      SPIN_R:  n = FILL_R;
      FILL_R:  n = RINSE;
      RINSE:   n = m[GRP_DRY] ? DRAIN_D : DONE;
      DRAIN_D: n = SPIN_D;
      default: n = DONE;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] phaseDur(input washState_t s, input logic [2:0] lvl);
    logic [7:0] d;
    case (s)
      FILL_W, FILL_R:   d = sat8(int'(lvl) * FILL_T);
      WASH:             d = sat8(WASH_T);
      RINSE:            d = sat8(RINSE_T);
      DRAIN_R, DRAIN_D: d = sat8(DRAIN_T);
      SPIN_R, SPIN_D:   d = sat8(SPIN_T);
      default:          d = 8'd0;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] totalDur(input logic [2:0] m, input logic [2:0] lvl);
    int t;
    t = (m[GRP_WASH]  ? int'(lvl) * FILL_T + WASH_T : 32'sd0)
      + (m[GRP_RINSE] ? DRAIN_T + SPIN_T + int'(lvl) * FILL_T + RINSE_T : 32'sd0)
      + (m[GRP_DRY]   ? DRAIN_T + SPIN_T : 32'sd0);
    return sat8(t);
  endfunction

  assign lvlIn_s      = (bus.water_lvl == 3'd0) ? 3'd1 : bus.water_lvl;
  assign running_s    = isRunning(state_r);
  assign userEvt_s    = bus.runBtn || bus.openBtn;
  assign countTick_s  = running_s && bus.tick_1s && !userEvt_s && !tmrZero_s;
  assign nextPhase_s  = followOn(state_r, mode_r);
  assign startState_s = followOn(IDLE, bus.mode);

  phase_timer uTimer (
    .clk     (clk),
    .rst     (resetBtn),
    .load    (tmrLoad_s),
    .loadVal (tmrVal_s),
    .tick    (bus.tick_1s),
    .hold    (!running_s || userEvt_s),
    .zero    (tmrZero_s)
  );

  // next-state and timer-load decode; operator buttons beat the tick
  always_comb begin
    nextState_s = state_r;
    tmrLoad_s   = 1'b0;
    tmrVal_s    = 8'd0;
    start_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.runBtn && !bus.openBtn && (bus.mode != 3'd0)) begin
          start_s     = 1'b1;
          nextState_s = startState_s;
          tmrLoad_s   = 1'b1;
          tmrVal_s    = phaseDur(startState_s, lvlIn_s);
        end else begin
          nextState_s = IDLE;
        end
      end
      DONE: begin
        if (bus.runBtn || (bus.openBtn && !openPrev_r)) begin
          nextState_s = IDLE;
        end else begin
          nextState_s = DONE;
        end
      end
      PAUSE: begin
        if (bus.runBtn && !bus.openBtn) begin
          nextState_s = stored_r;
        end else begin
          nextState_s = PAUSE;
        end
      end
      FILL_W, WASH, DRAIN_R, SPIN_R, FILL_R, RINSE, DRAIN_D, SPIN_D: begin
        if (userEvt_s) begin
          nextState_s = PAUSE;
        end else if (tmrZero_s) begin
          nextState_s = nextPhase_s;
          tmrLoad_s   = 1'b1;
          tmrVal_s    = phaseDur(nextPhase_s, lvl_r);
        end else begin
          nextState_s = state_r;
        end
      end
      default: nextState_s = IDLE;
    endcase
  end

  // state, latched programme settings and paused phase
  always_ff @(posedge clk or posedge resetBtn) begin
    if (resetBtn) begin
      state_r    <= IDLE;
      stored_r   <= IDLE;
      mode_r     <= 3'd0;
      lvl_r      <= 3'd1;
      openPrev_r <= 1'b0;
    end else begin
      state_r    <= nextState_s;
      openPrev_r <= bus.openBtn;
      if (start_s) begin
        mode_r <= bus.mode;
        lvl_r  <= lvlIn_s;
      end
      if (running_s && (nextState_s == PAUSE)) begin
        stored_r <= state_r;
      end
    end
  end

  // seconds-remaining counter for the whole programme
  always_ff @(posedge clk or posedge resetBtn) begin
    if (resetBtn) begin
      remaining_r <= 8'd0;
    end else if (start_s) begin
      remaining_r <= totalDur(bus.mode, lvlIn_s);
    end else if (nextState_s == IDLE) begin
      remaining_r <= 8'd0;
    end else if (countTick_s && (remaining_r != 8'd0)) begin
      remaining_r <= remaining_r - 8'd1;
    end else begin
      remaining_r <= remaining_r;
    end
  end

  // actuator and status outputs, registered in step with the state
  always_ff @(posedge clk or posedge resetBtn) begin
    if (resetBtn) begin
      inWater_r  <= 1'b0;
      washing_r  <= 1'b0;
      outWater_r <= 1'b0;
      spinning_r <= 1'b0;
      rinsing_r  <= 1'b0;
      busy_r     <= 1'b0;
      paused_r   <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      inWater_r  <= (nextState_s == FILL_W) || (nextState_s == FILL_R);
      washing_r  <= (nextState_s == WASH);
      outWater_r <= (nextState_s == DRAIN_R) || (nextState_s == DRAIN_D);
      spinning_r <= (nextState_s == SPIN_R) || (nextState_s == SPIN_D);
      rinsing_r  <= (nextState_s == RINSE);
      busy_r     <= (nextState_s != IDLE) && (nextState_s != DONE);
      paused_r   <= (nextState_s == PAUSE);
      done_r     <= (nextState_s == DONE);
    end
  end

  assign bus.inWater   = inWater_r;
  assign bus.washing   = washing_r;
  assign bus.outWater  = outWater_r;
  assign bus.spinning  = spinning_r;
  assign bus.rinsing   = rinsing_r;
  assign bus.busy      = busy_r;
  assign bus.paused    = paused_r;
  assign bus.done      = done_r;
  assign bus.phase     = state_r;
  assign bus.remaining = remaining_r;

`ifdef WASH_SEQ_BEEP_EN
  logic [1:0] beepCnt_r, beepCntNext_s;
  logic       beep_r;

  // seconds spent in DONE, saturating at three
  always_comb begin
    beepCntNext_s = beepCnt_r;
    if (state_r != DONE) begin
      beepCntNext_s = 2'd0;
    end else if (bus.tick_1s && (beepCnt_r != 2'd3)) begin
      beepCntNext_s = beepCnt_r + 2'd1;
    end else begin
      beepCntNext_s = beepCnt_r;
    end
  end

  // beep while in DONE until three ticks have elapsed
  always_ff @(posedge clk or posedge resetBtn) begin
    if (resetBtn) begin
      beepCnt_r <= 2'd0;
      beep_r    <= 1'b0;
    end else begin
      beepCnt_r <= beepCntNext_s;
      beep_r    <= (nextState_s == DONE) && (beepCntNext_s != 2'd3);
    end
  end

  assign bus.beep = beep_r;
`else
  assign bus.beep = 1'b0;
`endif

endmodule

// File: tb/tb_wash_sequencer.sv
// Self-checking bench for wash_sequencer: expected phases are queued at start
// and popped whenever the DUT changes phase.
module tb_wash_sequencer;

  localparam int FT = 2;
  localparam int WT = 3;
  localparam int RT = 2;
  localparam int DT = 2;
  localparam int ST = 2;

  localparam logic [3:0] P_IDLE    = 4'd0;
  localparam logic [3:0] P_FILL_W  = 4'd1;
  localparam logic [3:0] P_WASH    = 4'd2;
  localparam logic [3:0] P_DRAIN_R = 4'd3;
  localparam logic [3:0] P_SPIN_R  = 4'd4;
  localparam logic [3:0] P_FILL_R  = 4'd5;
  localparam logic [3:0] P_RINSE   = 4'd6;
  localparam logic [3:0] P_DRAIN_D = 4'd7;
  localparam logic [3:0] P_SPIN_D  = 4'd8;
  localparam logic [3:0] P_DONE    = 4'd9;
  localparam logic [3:0] P_PAUSE   = 4'd10;

  typedef struct {
    logic [3:0] phase;
    logic [4:0] act;
    logic [7:0] rem;
    int         dur;
  } expRec_t;

  expRec_t expQ[$];
  int totalCnt = 0;
  int badCnt   = 0;

  logic clk      = 1'b0;
  logic resetBtn = 1'b1;

  wash_sequencer_if bus ();

  wash_sequencer #(
    .FILL_T (FT),
    .WASH_T (WT),
    .RINSE_T(RT),
    .DRAIN_T(DT),
    .SPIN_T (ST)
  ) dut (
    .clk     (clk),
    .resetBtn(resetBtn),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got !== exp) begin
      badCnt++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] actOf(input logic [3:0] p);
    case (p)
      P_FILL_W, P_FILL_R:   return 5'b10000;
      P_WASH:               return 5'b01000;
      P_DRAIN_R, P_DRAIN_D: return 5'b00100;
      P_SPIN_R, P_SPIN_D:   return 5'b00010;
      P_RINSE:              return 5'b00001;
      default:              return 5'b00000;
    endcase
  endfunction

  function automatic logic [4:0] actNow();
    return {bus.inWater, bus.washing, bus.outWater, bus.spinning, bus.rinsing};
  endfunction

  task automatic pulseRun();
    bus.runBtn = 1'b1;
    @(negedge clk);
    bus.runBtn = 1'b0;
  endtask

  // one tick, then allow the phase advance that follows a zero crossing
  task automatic doTick();
    bus.tick_1s = 1'b1;
    @(negedge clk);
    bus.tick_1s = 1'b0;
    @(negedge clk);
  endtask

  task automatic pushPhase(input logic [3:0] p, input int d, inout int rem);
    expRec_t e;
    e.phase = p;
    e.act   = actOf(p);
    e.rem   = 8'(rem);
    e.dur   = d;
    expQ.push_back(e);
    rem -= d;
  endtask

  task automatic popCheck(input string tag, output logic [3:0] p, output int d);
    expRec_t e;
    e = expQ.pop_front();
    checkEq({tag, "-phase"}, bus.phase, e.phase);
    checkEq({tag, "-act"}, actNow(), e.act);
    checkEq({tag, "-remain"}, bus.remaining, e.rem);
    checkEq({tag, "-busy"}, bus.busy, e.phase != P_DONE);
    checkEq({tag, "-done"}, bus.done, e.phase == P_DONE);
    p = bus.phase;
    d = e.dur;
  endtask

  task automatic runCycle(input string tag, input logic [2:0] m, input logic [2:0] lvl);
    int tot, rem, spent, curDur;
    logic [3:0] cur;
    tot = (m[0] ? lvl * FT + WT : 0) + (m[1] ? DT + ST + lvl * FT + RT : 0) + (m[2] ? DT + ST : 0);
    rem = tot;
    expQ.delete();
    if (m[0]) begin
      pushPhase(P_FILL_W, lvl * FT, rem);
      pushPhase(P_WASH, WT, rem);
    end
    if (m[1]) begin
      pushPhase(P_DRAIN_R, DT, rem);
      pushPhase(P_SPIN_R, ST, rem);
      pushPhase(P_FILL_R, lvl * FT, rem);
      pushPhase(P_RINSE, RT, rem);
    end
    if (m[2]) begin
      pushPhase(P_DRAIN_D, DT, rem);
      pushPhase(P_SPIN_D, ST, rem);
    end
    pushPhase(P_DONE, 0, rem);
    bus.mode      = m;
    bus.water_lvl = lvl;
    pulseRun();
    popCheck(tag, cur, curDur);
    rem   = tot;
    spent = 0;
    for (int t = 0; (t < tot + 4) && (expQ.size() > 0); t++) begin
      doTick();
      spent++;
      if (rem > 0) rem--;
      checkEq({tag, "-tickrem"}, bus.remaining, rem);
      if (bus.phase != cur) begin
        checkEq({tag, "-dur"}, spent, curDur);
        popCheck(tag, cur, curDur);
        spent = 0;
      end
    end
    checkEq({tag, "-drained"}, expQ.size(), 0);
  endtask

  initial begin
    bus.runBtn    = 1'b0;
    bus.openBtn   = 1'b0;
    bus.tick_1s   = 1'b0;
    bus.mode      = 3'b000;
    bus.water_lvl = 3'd1;
    repeat (3) @(negedge clk);
    checkEq("rst-phase", bus.phase, P_IDLE);
    checkEq("rst-act", actNow(), 5'b00000);
    checkEq("rst-remain", bus.remaining, 0);
    checkEq("rst-status", {bus.busy, bus.paused, bus.done, bus.beep}, 4'b0000);
    resetBtn = 1'b0;
    @(negedge clk);
    checkEq("idle-no-start", bus.phase, P_IDLE);

    // wash only, then the end-of-cycle beep
    runCycle("wash", 3'b001, 3'd1);
`ifdef WASH_SEQ_BEEP_EN
    checkEq("beep-enter", bus.beep, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      doTick();
      checkEq("beep-tick", bus.beep, k < 3);
    end
`else
    doTick();
    checkEq("beep-off", bus.beep, 1'b0);
`endif
    pulseRun();
    checkEq("done-run-idle", bus.phase, P_IDLE);
    checkEq("done-run-beep", bus.beep, 1'b0);

    // full programme at water level 2
    runCycle("full", 3'b111, 3'd2);
    pulseRun();
    checkEq("full-idle", bus.phase, P_IDLE);

    // ignored starts
    bus.mode = 3'b000;
    pulseRun();
    checkEq("mode0-ign", bus.phase, P_IDLE);
    bus.mode    = 3'b001;
    bus.openBtn = 1'b1;
    pulseRun();
    checkEq("open-ign", bus.phase, P_IDLE);
    checkEq("open-ign-busy", bus.busy, 1'b0);
    bus.openBtn = 1'b0;
    @(negedge clk);

    // pause mid-WASH with two seconds left
    bus.water_lvl = 3'd1;
    pulseRun();
    repeat (3) doTick();
    checkEq("pz-wash", bus.phase, P_WASH);
    checkEq("pz-rem", bus.remaining, 2);
    pulseRun();
    checkEq("pz-phase", bus.phase, P_PAUSE);
    checkEq("pz-flags", {bus.paused, bus.busy, bus.washing}, 3'b110);
    for (int k = 0; k < 5; k++) begin
      doTick();
      checkEq("pz-hold-phase", bus.phase, P_PAUSE);
      checkEq("pz-hold-rem", bus.remaining, 2);
    end
    pulseRun();
    checkEq("pz-resume", bus.phase, P_WASH);
    checkEq("pz-resume-act", actNow(), 5'b01000);
    doTick();
    checkEq("pz-t1", bus.phase, P_WASH);
    doTick();
    checkEq("pz-t2", bus.phase, P_DONE);
    checkEq("pz-t2-rem", bus.remaining, 0);
    bus.openBtn = 1'b1;
    @(negedge clk);
    checkEq("done-open-idle", bus.phase, P_IDLE);
    bus.openBtn = 1'b0;
    @(negedge clk);

    // tick and runBtn together: tick discarded
    pulseRun();
    doTick();
    checkEq("same-pre-rem", bus.remaining, 4);
    bus.tick_1s = 1'b1;
    bus.runBtn  = 1'b1;
    @(negedge clk);
    bus.tick_1s = 1'b0;
    bus.runBtn  = 1'b0;
    checkEq("same-phase", bus.phase, P_PAUSE);
    checkEq("same-rem", bus.remaining, 4);
    pulseRun();
    checkEq("same-resume", bus.phase, P_FILL_W);
    doTick();
    checkEq("same-timer", bus.phase, P_WASH);
    checkEq("same-rem2", bus.remaining, 3);
    resetBtn = 1'b1;
    @(negedge clk);
    resetBtn = 1'b0;
    @(negedge clk);

    // door opened during SPIN_R, then reset in RINSE
    bus.mode = 3'b010;
    pulseRun();
    checkEq("door-drain", bus.phase, P_DRAIN_R);
    checkEq("door-total", bus.remaining, 8);
    repeat (2) doTick();
    checkEq("door-spin", bus.phase, P_SPIN_R);
    checkEq("door-spin-act", bus.spinning, 1'b1);
    doTick();
    bus.openBtn = 1'b1;
    @(negedge clk);
    checkEq("door-pause", bus.phase, P_PAUSE);
    checkEq("door-spin-off", bus.spinning, 1'b0);
    pulseRun();
    checkEq("door-run-ign", bus.phase, P_PAUSE);
    bus.openBtn = 1'b0;
    @(negedge clk);
    checkEq("door-closed-wait", bus.phase, P_PAUSE);
    pulseRun();
    checkEq("door-resume", bus.phase, P_SPIN_R);
    checkEq("door-resume-rem", bus.remaining, 5);
    doTick();
    checkEq("door-fillr", bus.phase, P_FILL_R);
    repeat (2) doTick();
    checkEq("door-rinse", bus.phase, P_RINSE);
    checkEq("door-rinse-act", actNow(), 5'b00001);
    doTick();
    resetBtn = 1'b1;
    #1;
    checkEq("mid-rst-phase", bus.phase, P_IDLE);
    checkEq("mid-rst-act", actNow(), 5'b00000);
    checkEq("mid-rst-rem", bus.remaining, 0);
    checkEq("mid-rst-status", {bus.busy, bus.paused, bus.done, bus.beep}, 4'b0000);
    @(negedge clk);
    resetBtn = 1'b0;
    repeat (2) @(negedge clk);
    checkEq("post-rst-idle", bus.phase, P_IDLE);
    bus.mode = 3'b001;
    pulseRun();
    checkEq("post-rst-start", bus.phase, P_FILL_W);

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
